// File: rtl/load_wb_queue_pkg.sv
// load_wb_queue_pkg: shared core load defines (funct3 encodings, XLEN legality check, zero register)
package load_wb_queue_pkg;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LD  = 3'b011,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101,
        F3_LWU = 3'b110
    } load_f3_e;

    // LD and LWU only exist on a 64-bit core; 111 is never a load.
    function automatic logic f3_legal(input logic [2:0] f3, input int xlen);
        return !(f3 == 3'b111 || (xlen == 32 && (f3 == F3_LD || f3 == F3_LWU)));
    endfunction

endpackage

// File: rtl/load_wb_queue_if.sv
// load_wb_queue_if: load request/response/writeback bundle
//   master: issues requests, returns memory data, flushes; sees ready, writeback and status
//   slave : the queue itself
interface load_wb_queue_if #(parameter int XLEN = 32, parameter int DEPTH = 4);

    localparam int OFFW = $clog2(XLEN / 8);
    localparam int CW   = $clog2(DEPTH) + 1;

    logic            req_valid;
    logic            req_ready;
    logic [4:0]      req_rd;
    logic [OFFW-1:0] req_offset;
    logic [2:0]      req_funct3;
    logic            rsp_valid;
    logic [XLEN-1:0] rsp_data;
    logic            flush;
    logic            reg_we;
    logic [4:0]      reg_waddr;
    logic [XLEN-1:0] reg_wdata;
    logic            load_err;
    logic            empty;
    logic [CW-1:0]   count;

    modport master (
        output req_valid, req_rd, req_offset, req_funct3, rsp_valid, rsp_data, flush,
        input  req_ready, reg_we, reg_waddr, reg_wdata, load_err, empty, count
    );

    modport slave (
        input  req_valid, req_rd, req_offset, req_funct3, rsp_valid, rsp_data, flush,
        output req_ready, reg_we, reg_waddr, reg_wdata, load_err, empty, count
    );

endinterface

// File: rtl/load_align.sv
// load_align: selects and extends the loaded byte/half/word from an aligned memory word
//   in : data (raw word), offset (low address bits), funct3 (load type)
//   out: wdata (extended value), misaligned, illegal
module load_align import load_wb_queue_pkg::*; #(
    parameter int XLEN = 32,
    parameter int OFFW = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0] data,
    input  logic [OFFW-1:0] offset,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] wdata,
    output logic            misaligned,
    output logic            illegal
);

    logic [OFFW-1:0] base;
    logic [XLEN-1:0] sel;
    logic            uns;

    // Round the offset down to the access size so one shifter serves every width.
    always_comb begin
        uns  = funct3[2];
        base = funct3[1:0] == 2'b00 ? offset :
               funct3[1:0] == 2'b01 ? offset & ~OFFW'(1) :
               funct3[1:0] == 2'b10 ? offset & ~OFFW'(3) : '0;
        sel  = data >> {base, 3'b000};
        wdata = funct3[1:0] == 2'b00 ? (uns ? XLEN'(sel[7:0])  : XLEN'($signed(sel[7:0]))) :
                funct3[1:0] == 2'b01 ? (uns ? XLEN'(sel[15:0]) : XLEN'($signed(sel[15:0]))) :
                funct3[1:0] == 2'b10 ? (uns ? XLEN'(sel[31:0]) : XLEN'($signed(sel[31:0]))) : sel;
        misaligned = (funct3[1:0] == 2'b01 && offset[0]) || (funct3[1:0] == 2'b10 && offset[1:0] != 2'b00);
        illegal    = !f3_legal(funct3, XLEN);
    end

endmodule

// File: rtl/load_wb_queue.sv
// load_wb_queue: in-order queue of outstanding loads pairing memory responses with their
// destination register, producing a registered register-file write
//   clk, rst : clock, synchronous active-high reset
//   bus      : request push, response pop, flush, writeback port, load_err, empty, count
module load_wb_queue import load_wb_queue_pkg::*; #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input logic           clk,
    input logic           rst,
    load_wb_queue_if.slave bus
);

    localparam int OFFW = $clog2(XLEN / 8);
    localparam int AW   = $clog2(DEPTH);

    typedef struct packed {
        logic [4:0]      rd;
        logic [OFFW-1:0] off;
        logic [2:0]      f3;
    } entry_t;

    entry_t          pay_q [DEPTH];
    entry_t          pay_d [DEPTH];
    logic [DEPTH-1:0] killed_q, killed_d;
    logic [AW:0]     wp_q, wp_d, rp_q, rp_d;
    logic            we_q, we_d, err_q, err_d;
    logic [4:0]      waddr_q, waddr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic            empty, full, push, pop, kill, wb, mis, ill;
    logic [XLEN-1:0] al_wdata;
    entry_t          head;

    // Extra pointer MSB tells full (MSBs differ) from empty (pointers equal).
    assign empty = wp_q == rp_q;
    assign full  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    assign push  = bus.req_valid & bus.req_ready;
    assign pop   = bus.rsp_valid & !empty;
    assign head  = pay_q[rp_q[AW-1:0]];
    // A flush in the pop cycle also kills the entry leaving the queue.
    assign kill  = killed_q[rp_q[AW-1:0]] | bus.flush;
    assign wb    = pop & !kill & (head.rd != REG_ZERO);

    load_align #(.XLEN(XLEN)) u_align (
        .data      (bus.rsp_data),
        .offset    (head.off),
        .funct3    (head.f3),
        .wdata     (al_wdata),
        .misaligned(mis),
        .illegal   (ill)
    );

    // Flush may mark free slots killed too; a push always clears its slot's bit.
    always_comb begin
        pay_d    = pay_q;
        killed_d = bus.flush ? '1 : killed_q;
        if (push) begin
            pay_d[wp_q[AW-1:0]]    = '{rd: bus.req_rd, off: bus.req_offset, f3: bus.req_funct3};
            killed_d[wp_q[AW-1:0]] = 1'b0;
        end
        wp_d    = wp_q + {{AW{1'b0}}, push};
        rp_d    = rp_q + {{AW{1'b0}}, pop};
        we_d    = wb & !mis & !ill;
        err_d   = (wb & (mis | ill)) | (bus.rsp_valid & empty);
        waddr_d = we_d ? head.rd : '0;
        wdata_d = we_d ? al_wdata : '0;
    end

    always_ff @(posedge clk) begin
        pay_q <= pay_d;
        if (rst) begin
            wp_q     <= '0;
            rp_q     <= '0;
            killed_q <= '0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            wp_q     <= wp_d;
            rp_q     <= rp_d;
            killed_q <= killed_d;
            we_q     <= we_d;
            err_q    <= err_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign bus.req_ready = !full & !bus.flush;
    assign bus.empty     = empty;
    assign bus.count     = wp_q - rp_q;
    assign bus.reg_we    = we_q;
    assign bus.reg_waddr = waddr_q;
    assign bus.reg_wdata = wdata_q;
    assign bus.load_err  = err_q;

endmodule

// File: tb/tb_load_wb_queue.sv
// tb_load_wb_queue: drives identical load streams into 32- and 64-bit queues and scoreboards writebacks
module tb_load_wb_queue;

    localparam int DEPTH = 4;

    typedef struct {
        logic [4:0] rd;
        logic [2:0] off;
        logic [2:0] f3;
        bit         killed;
    } ent_t;

    typedef struct {
        logic        err;
        logic        we;
        logic [4:0]  waddr;
        logic [63:0] wdata;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    ent_t mq0[$], mq1[$];
    res_t sb0[$], sb1[$];

    load_wb_queue_if #(.XLEN(32), .DEPTH(DEPTH)) i32();
    load_wb_queue_if #(.XLEN(64), .DEPTH(DEPTH)) i64();

    load_wb_queue #(.XLEN(32), .DEPTH(DEPTH)) u32 (.clk(clk), .rst(rst), .bus(i32.slave));
    load_wb_queue #(.XLEN(64), .DEPTH(DEPTH)) u64 (.clk(clk), .rst(rst), .bus(i64.slave));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic res_t model(input ent_t e, input logic [63:0] d, input int xlen, input bit fl);
        res_t r;
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] w;
        logic [63:0] v;
        bit          bad;
        r = '{1'b0, 1'b0, 5'd0, 64'd0};
        b = d[8*e.off +: 8];
        h = d[8*(e.off & 3'd6) +: 16];
        w = d[8*(e.off & 3'd4) +: 32];
        case (e.f3)
            3'b000:  v = {{56{b[7]}}, b};
            3'b100:  v = {56'd0, b};
            3'b001:  v = {{48{h[15]}}, h};
            3'b101:  v = {48'd0, h};
            3'b010:  v = {{32{w[31]}}, w};
            3'b110:  v = {32'd0, w};
            default: v = d;
        endcase
        if (xlen == 32) v = v & 64'hFFFF_FFFF;
        bad = (e.f3 == 3'b111) || (xlen == 32 && (e.f3 == 3'b011 || e.f3 == 3'b110)) ||
              ((e.f3 == 3'b001 || e.f3 == 3'b101) && e.off[0]) ||
              ((e.f3 == 3'b010 || e.f3 == 3'b110) && e.off[1:0] != 2'b00);
        if (!(e.killed || fl) && e.rd != 5'd0) begin
            if (bad) r.err = 1'b1;
            else begin
                r.we    = 1'b1;
                r.waddr = e.rd;
                r.wdata = v;
            end
        end
        return r;
    endfunction

    task automatic drive(input logic pv, input logic [4:0] rd, input logic [2:0] off, input logic [2:0] f3,
                         input logic rv, input logic [63:0] data, input logic fl);
        i32.req_valid = pv;          i64.req_valid = pv;
        i32.req_rd = rd;             i64.req_rd = rd;
        i32.req_offset = off[1:0];   i64.req_offset = off;
        i32.req_funct3 = f3;         i64.req_funct3 = f3;
        i32.rsp_valid = rv;          i64.rsp_valid = rv;
        i32.rsp_data = data[31:0];   i64.rsp_data = data;
        i32.flush = fl;              i64.flush = fl;
    endtask

    task automatic chk_wb(input string p, input logic we, input logic [4:0] wa, input logic [63:0] wd,
                          input logic err, input res_t r);
        chk({p, "_we"}, we, r.we);
        chk({p, "_waddr"}, wa, r.waddr);
        chk({p, "_wdata"}, wd, r.wdata);
        chk({p, "_err"}, err, r.err);
    endtask

    task automatic cyc(input logic pv, input logic [4:0] rd, input logic [2:0] off, input logic [2:0] f3,
                       input logic rv, input logic [63:0] data, input logic fl);
        ent_t e;
        bit   rdy0, rdy1;
        drive(pv, rd, off, f3, rv, data, fl);
        #1;
        rdy0 = mq0.size() < DEPTH && !fl;
        rdy1 = mq1.size() < DEPTH && !fl;
        chk("ready32", i32.req_ready, rdy0);
        chk("ready64", i64.req_ready, rdy1);
        if (rv) begin
            if (mq0.size() == 0) sb0.push_back('{1'b1, 1'b0, 5'd0, 64'd0});
            else begin
                e = mq0.pop_front();
                sb0.push_back(model(e, data & 64'hFFFF_FFFF, 32, fl));
            end
            if (mq1.size() == 0) sb1.push_back('{1'b1, 1'b0, 5'd0, 64'd0});
            else begin
                e = mq1.pop_front();
                sb1.push_back(model(e, data, 64, fl));
            end
        end
        if (fl) begin
            foreach (mq0[i]) mq0[i].killed = 1'b1;
            foreach (mq1[i]) mq1[i].killed = 1'b1;
        end
        if (pv && rdy0) mq0.push_back('{rd, off & 3'd3, f3, 1'b0});
        if (pv && rdy1) mq1.push_back('{rd, off, f3, 1'b0});
        @(posedge clk);
        #1;
        drive(1'b0, 5'd0, 3'd0, 3'd0, 1'b0, 64'd0, 1'b0);
        if (rv) begin
            chk_wb("wb32", i32.reg_we, i32.reg_waddr, {32'd0, i32.reg_wdata}, i32.load_err, sb0.pop_front());
            chk_wb("wb64", i64.reg_we, i64.reg_waddr, i64.reg_wdata, i64.load_err, sb1.pop_front());
        end else begin
            chk("idle_we32", {i32.reg_we, i32.load_err}, 2'b00);
            chk("idle_we64", {i64.reg_we, i64.load_err}, 2'b00);
        end
        chk("count32", i32.count, mq0.size());
        chk("count64", i64.count, mq1.size());
        chk("empty32", i32.empty, mq0.size() == 0);
        chk("empty64", i64.empty, mq1.size() == 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 5'd0, 3'd0, 3'd0, 1'b0, 64'd0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mq0.delete(); mq1.delete(); sb0.delete(); sb1.delete();
        chk("rst_empty32", i32.empty, 1'b1);
        chk("rst_empty64", i64.empty, 1'b1);
        chk("rst_count32", i32.count, 0);
        chk("rst_count64", i64.count, 0);
        chk("rst_out32", {i32.reg_we, i32.reg_waddr, i32.reg_wdata, i32.load_err}, 0);
        chk("rst_out64", {i64.reg_we, i64.reg_waddr, i64.reg_wdata, i64.load_err}, 0);
        chk("rst_ready32", i32.req_ready, 1'b1);
    endtask

    initial begin
        drive(1'b0, 5'd0, 3'd0, 3'd0, 1'b0, 64'd0, 1'b0);
        @(posedge clk);
        do_reset();
        // LB sign extension
        cyc(1, 5'd5, 3'd2, 3'b000, 0, 64'd0, 0);
        cyc(0, 5'd0, 3'd0, 3'b000, 1, 64'h0000_0000_1280_3456, 0);
        chk("lb_wdata32", i32.reg_wdata, 64'hFFFF_FF80);
        chk("lb_waddr32", i32.reg_waddr, 5'd5);
        // LWU then LD on the 64-bit core; both illegal on the 32-bit core
        cyc(1, 5'd7, 3'd4, 3'b110, 0, 64'd0, 0);
        cyc(1, 5'd8, 3'd0, 3'b011, 0, 64'd0, 0);
        cyc(0, 5'd0, 3'd0, 3'b000, 1, 64'h8000_0001_DEAD_BEEF, 0);
        chk("lwu_wdata64", i64.reg_wdata, 64'h0000_0000_8000_0001);
        chk("lwu_err32", i32.load_err, 1'b1);
        cyc(0, 5'd0, 3'd0, 3'b000, 1, 64'h0123_4567_89AB_CDEF, 0);
        chk("ld_wdata64", i64.reg_wdata, 64'h0123_4567_89AB_CDEF);
        // fill to DEPTH, attempts while full, push+pop together, drain
        cyc(1, 5'd1, 3'd2, 3'b001, 0, 64'd0, 0);
        cyc(1, 5'd2, 3'd3, 3'b100, 0, 64'd0, 0);
        cyc(1, 5'd3, 3'd2, 3'b101, 0, 64'd0, 0);
        cyc(1, 5'd4, 3'd0, 3'b010, 0, 64'd0, 0);
        chk("full_count32", i32.count, 3'd4);
        cyc(1, 5'd9, 3'd0, 3'b010, 0, 64'd0, 0);
        cyc(1, 5'd10, 3'd0, 3'b000, 1, 64'hFEDC_BA98_8765_4321, 0);
        cyc(1, 5'd11, 3'd1, 3'b000, 1, 64'h1111_2222_F3F4_A5B6, 0);
        cyc(0, 5'd0, 3'd0, 3'b000, 1, 64'hAAAA_BBBB_8001_7FFF, 0);
        cyc(0, 5'd0, 3'd0, 3'b000, 1, 64'hCAFE_F00D_9ABC_DEF0, 0);
        cyc(0, 5'd0, 3'd0, 3'b000, 1, 64'h0000_0000_0000_00C3, 0);
        // flush with first response kills all three; next push is live
        cyc(1, 5'd12, 3'd0, 3'b010, 0, 64'd0, 0);
        cyc(1, 5'd13, 3'd1, 3'b000, 0, 64'd0, 0);
        cyc(1, 5'd14, 3'd2, 3'b001, 0, 64'd0, 0);
        cyc(1, 5'd15, 3'd0, 3'b000, 1, 64'h1234_5678_9ABC_DEF0, 1);
        cyc(1, 5'd20, 3'd0, 3'b010, 1, 64'h5555_5555_5555_5555, 0);
        cyc(0, 5'd0, 3'd0, 3'b000, 1, 64'h6666_6666_6666_6666, 0);
        cyc(0, 5'd0, 3'd0, 3'b000, 1, 64'h7777_7777_8765_4321, 0);
        chk("post_flush_we32", i32.reg_we, 1'b1);
        // misaligned, response while empty, rd=0, funct3=111
        cyc(1, 5'd3, 3'd1, 3'b001, 0, 64'd0, 0);
        cyc(0, 5'd0, 3'd0, 3'b000, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        chk("mis_err32", i32.load_err, 1'b1);
        cyc(0, 5'd0, 3'd0, 3'b000, 1, 64'h0000_0000_0000_1234, 0);
        chk("empty_rsp_err64", i64.load_err, 1'b1);
        cyc(1, 5'd0, 3'd1, 3'b000, 0, 64'd0, 0);
        cyc(0, 5'd0, 3'd0, 3'b000, 1, 64'h0000_0000_0000_FF00, 0);
        cyc(1, 5'd6, 3'd0, 3'b111, 0, 64'd0, 0);
        cyc(0, 5'd0, 3'd0, 3'b000, 1, 64'h0000_0000_0000_0042, 0);
        // reset with two outstanding, then a stray response
        cyc(1, 5'd21, 3'd0, 3'b000, 0, 64'd0, 0);
        cyc(1, 5'd22, 3'd0, 3'b000, 0, 64'd0, 0);
        do_reset();
        cyc(0, 5'd0, 3'd0, 3'b000, 1, 64'h0000_0000_0000_0011, 0);
        // mixed traffic
        for (int i = 0; i < 40; i++)
            cyc(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)),
                3'($urandom_range(0, 7)), 1'($urandom_range(0, 2) == 0), {$urandom, $urandom},
                1'($urandom_range(0, 9) == 0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
